// File: rtl/pdp6_membus_pkg.sv
// Shared PDP-6 memory-bus types and widths.
// Holds the bridge state encoding, address width and word width.
package pdp6_membus;

  localparam int AW = 18;
  localparam int DW = 36;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_READ   = 3'd2,
    ST_ACK    = 3'd3,
    ST_RDRS   = 3'd4,
    ST_WAITWR = 3'd5,
    ST_WRITE  = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

endpackage

// File: rtl/membus_bridge.sv
// Bridge from PDP-6 membus processor cycles to a stall-based memory port.
// Ports: membus rq_cyc/rd_rq/wr_rq/ma/wr_rs/mb_in in, addr_ack/rd_rs/mb_out
// and timeout out; memory address/read/write/writedata out, readdata and
// waitrequest in. Single clock i_clk, synchronous active-low i_reset_n.
module membus_bridge
  import pdp6_membus::*;
#(
  parameter int WR_TIMEOUT = 1023
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_membus_rq_cyc,
  input  logic          i_membus_rd_rq,
  input  logic          i_membus_wr_rq,
  input  logic [AW-1:0] i_membus_ma,
  input  logic          i_membus_wr_rs,
  input  logic [DW-1:0] i_membus_mb_in,
  output logic          o_membus_addr_ack,
  output logic          o_membus_rd_rs,
  output logic [DW-1:0] o_membus_mb_out,
  output logic          o_timeout,
  output logic [AW-1:0] o_address,
  output logic          o_read,
  output logic          o_write,
  output logic [DW-1:0] o_writedata,
  input  logic [DW-1:0] i_readdata,
  input  logic          i_waitrequest
);

  localparam int TW = $clog2(WR_TIMEOUT + 1);
  localparam int CW = (TW > 10) ? TW : 10;
  localparam logic [CW-1:0] TMO = CW'(WR_TIMEOUT);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] mb_q;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] cnt_q;
  logic          rd_q, wr_q;
  logic          abort_q;
  logic          wack_q;

  logic start;
  logic cyc_gone;
  logic tmo_hit;
  logic mem_done;

  assign start    = (state_q == ST_IDLE) && i_membus_rq_cyc
                    && (i_membus_rd_rq || i_membus_wr_rq);
  // Once rq_cyc drops mid-transfer, the transfer finishes silently.
  assign cyc_gone = abort_q || !i_membus_rq_cyc;
  assign mem_done = !i_waitrequest;
  // A wr_rs in the expiry cycle beats the timeout.
  assign tmo_hit  = (state_q == ST_WAITWR) && i_membus_rq_cyc
                    && !i_membus_wr_rs && (cnt_q == TMO);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (!i_membus_rq_cyc) state_d = ST_IDLE;
        else if (rd_q)        state_d = ST_READ;
        else                  state_d = ST_WAITWR;
      end
      ST_READ: begin
        if (mem_done) state_d = cyc_gone ? ST_IDLE : ST_ACK;
      end
      ST_ACK: begin
        state_d = i_membus_rq_cyc ? ST_RDRS : ST_IDLE;
      end
      ST_RDRS: begin
        if (!i_membus_rq_cyc) state_d = ST_IDLE;
        else if (wr_q)        state_d = ST_WAITWR;
        else                  state_d = ST_DONE;
      end
      ST_WAITWR: begin
        if (!i_membus_rq_cyc)    state_d = ST_IDLE;
        else if (i_membus_wr_rs) state_d = ST_WRITE;
        else if (cnt_q == TMO)   state_d = ST_DONE;
      end
      ST_WRITE: begin
        if (mem_done) state_d = cyc_gone ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        if (!i_membus_rq_cyc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      addr_q  <= '0;
      mb_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
      wack_q  <= 1'b0;
    end else begin
      if (start) begin
        addr_q <= i_membus_ma;
        rd_q   <= i_membus_rd_rq;
        wr_q   <= i_membus_wr_rq;
      end
      if (state_q == ST_WAITWR && i_membus_rq_cyc && i_membus_wr_rs)
        wdata_q <= i_membus_mb_in;
      if (state_d == ST_IDLE)
        mb_q <= '0;
      else if (state_q == ST_READ && mem_done && !cyc_gone)
        mb_q <= i_readdata;
      cnt_q <= (state_q == ST_WAITWR && state_d == ST_WAITWR)
               ? cnt_q + 1'b1 : '0;
      // Write-only cycles acknowledge the address on WAITWR entry.
      wack_q <= (state_q == ST_SETUP) && (state_d == ST_WAITWR);
      if (state_d == ST_IDLE)
        abort_q <= 1'b0;
      else if ((state_q == ST_READ || state_q == ST_WRITE)
               && !i_membus_rq_cyc)
        abort_q <= 1'b1;
    end
  end

  always_comb begin
    o_read            = (state_q == ST_READ);
    o_write           = (state_q == ST_WRITE);
    o_membus_addr_ack = (state_q == ST_ACK) || wack_q;
    o_membus_rd_rs    = (state_q == ST_RDRS);
    o_timeout         = tmo_hit;
    o_address         = addr_q;
    o_writedata       = wdata_q;
    o_membus_mb_out   = '0;
    // Wired-OR bus: drive the word only once rd_rs has delivered it.
    if (state_q == ST_RDRS || state_q == ST_WAITWR
        || state_q == ST_WRITE || state_q == ST_DONE)
      o_membus_mb_out = mb_q;
  end

endmodule

// File: doc/membus_bridge.md
MEMBUS_BRIDGE -- requirements
Module: membus_bridge

Interface
REQ-001 Parameter WR_TIMEOUT, default 1023, meaning the number of cycles to wait for write-restart before the cycle is abandoned.
REQ-002 The design SHALL have one clock; reset is synchronous and active-low; ports are i_clk and i_reset_n.
REQ-003 i_clk  in  1  clock; all state changes on the rising edge.
REQ-004 i_reset_n  in  1  synchronous active-low reset.
REQ-005 i_membus_rq_cyc  in  1  processor request cycle, level, held for the whole cycle.
REQ-006 i_membus_rd_rq / i_membus_wr_rq  in  1 each  read / write request, sampled at cycle start; both set means read-modify-write.
REQ-007 i_membus_ma  in  18  word address, sampled at cycle start.
REQ-008 i_membus_wr_rs  in  1  write-restart pulse; i_membus_mb_in is valid in the same cycle.
REQ-009 i_membus_mb_in  in  36  write data from the processor.
REQ-010 o_membus_addr_ack / o_membus_rd_rs  out  1 each  one-cycle pulses to the processor.
REQ-011 o_membus_mb_out  out  36  read data; 0 when not valid (wired-OR bus).
REQ-012 o_timeout  out  1  one-cycle pulse when WR_TIMEOUT expires.
REQ-013 o_address  out  18  memory-side address.
REQ-014 o_read / o_write  out  1 each  memory-side strobes.
REQ-015 o_writedata  out  36  memory-side write data.
REQ-016 i_readdata  in  36  memory-side read data.
REQ-017 i_waitrequest  in  1  memory-side stall.

Function
REQ-018 States SHALL be IDLE, SETUP, READ, ACK, RDRS, WAITWR, WRITE, DONE.
REQ-019 IDLE: when rq_cyc=1 and (rd_rq|wr_rq)=1, latch ma, rd_rq and wr_rq, drive o_address, and go to SETUP; with rq_cyc=1 and neither request set, stay in IDLE.
REQ-020 SETUP (exactly one cycle, address stable before strobe): if the latched read flag is set, go to READ; otherwise pulse addr_ack in the next cycle and go to WAITWR.
REQ-021 READ: o_read=1 until i_waitrequest is sampled 0; in that cycle latch i_readdata into the mb_out register, drop o_read, and go to ACK.
REQ-022 ACK: addr_ack=1 for one cycle, then go to RDRS.
REQ-023 RDRS: rd_rs=1 for one cycle with mb_out valid; next state is WAITWR if the write flag is set, otherwise DONE.
REQ-024 mb_out SHALL stay valid from RDRS until the return to IDLE.
REQ-025 WAITWR: on wr_rs, latch mb_in into o_writedata and go to WRITE.
REQ-026 WAITWR: a 10-bit-minimum counter SHALL count from 0 each cycle in this state.
REQ-027 WAITWR: on reaching WR_TIMEOUT with no wr_rs, pulse o_timeout, perform no write, and go to DONE.
REQ-028 WAITWR: wr_rs arriving in the same cycle as the timeout count SHALL win, so the write happens and there is no timeout.
REQ-029 WRITE: o_write=1 until i_waitrequest is sampled 0, then drop o_write and go to DONE.
REQ-030 o_address and o_writedata SHALL stay stable until one cycle after the strobe drops.
REQ-031 DONE: wait for rq_cyc=0, then clear mb_out and go to IDLE.
REQ-032 rq_cyc dropping during READ or WRITE: the memory transaction SHALL complete, with no further membus pulses, then go to IDLE.
REQ-033 rq_cyc dropping during SETUP, ACK, RDRS or WAITWR: go to IDLE at once with no memory write.
REQ-034 At most one strobe SHALL be active at a time, and a strobe is never active in IDLE.
REQ-035 Latency, read (memory wait 1 cycle): rq_cyc seen at cycle 0 gives read at cycle 2, addr_ack at cycle 4, rd_rs at cycle 5.
REQ-036 wr_rs pulses outside WAITWR SHALL be ignored.

Reset
REQ-037 With i_reset_n=0 at a clock edge: state goes to IDLE; every output, the mb_out register, the latched flags and the counter go to 0.
REQ-038 Reset during any state SHALL abandon the cycle with no pulses and no strobe in the following cycle.

Structure
REQ-039 The state encoding, the 18-bit address width and the 36-bit word width SHALL live in a shared pdp6_membus package.
REQ-040 The design SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-041 Read: ma=0o1234, memory word 0o123456654321, wait 1 -> o_read for 2 cycles at address 0o1234; addr_ack then rd_rs; mb_out=0o123456654321 until rq_cyc drops, then 0.
REQ-042 Write-only: ma=0o00077, addr_ack, then wr_rs with mb_in=0o777777000000 three cycles later -> one write of 0o777777000000 at 0o77; read-back matches.
REQ-043 Read-modify-write: rd and wr at 0o500, old word 5, then wr_rs with data 6 -> rd_rs delivers 5, memory holds 6, exactly one read and one write strobe.
REQ-044 Timeout: WR_TIMEOUT=8, write-only, no wr_rs -> o_timeout pulse 8 cycles after entering WAITWR, no o_write, DONE until rq_cyc=0.
REQ-045 Abort: rq_cyc dropped during WAITWR -> IDLE next cycle, no write; rq_cyc dropped during READ -> read completes, no addr_ack or rd_rs.
REQ-046 Reset mid-WRITE with waitrequest held 1 -> next cycle o_write=0, all outputs 0, IDLE; a new read afterwards succeeds.
